// File: rtl/nem_ohmux_sel_ctrl_pkg.sv
// Shared types and helpers for the NEM-relay one-hot mux select sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: sequencer state enum, onehot() lane decoder, default dwell lengths.
package nem_sel_pkg;

    localparam int BREAK_CYC_DEF = 4;
    localparam int MAKE_CYC_DEF  = 8;

    // Widest lane vector onehot() can build; callers size-cast down to N_IN.
    localparam int MAX_LANES = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_MAKE  = 2'd2,
        ST_HOLD  = 2'd3
    } sel_state_t;

    // Lane vector with only bit 'index' set; all-zero when index >= n.
    function automatic logic [MAX_LANES-1:0] onehot(input int unsigned index,
                                                    input int unsigned n);
        logic [MAX_LANES-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            v[i] = (i < n) && (i == index);
        end
        return v;
    endfunction

endpackage

// File: rtl/nem_ohmux_sel_ctrl_if.sv
// Request/status bundle between a select requester and the relay sequencer.
// Latency: n/a (wires only).
// Backpressure: REQ_READY from the sequencer gates REQ_VALID.
// Signals: REQ_VALID/REQ_SEL/REQ_OFF in, REQ_READY/S/CUR_SEL/SEL_VALID/ERR back.
interface nem_ohmux_sel_ctrl_if #(
    parameter int N_IN  = 2,
    parameter int SEL_W = $clog2(N_IN)
);
    logic             REQ_VALID;
    logic [SEL_W-1:0] REQ_SEL;
    logic             REQ_OFF;
    logic             REQ_READY;
    logic [N_IN-1:0]  S;
    logic [SEL_W-1:0] CUR_SEL;
    logic             SEL_VALID;
    logic             ERR;

    modport master (
        output REQ_VALID, REQ_SEL, REQ_OFF,
        input  REQ_READY, S, CUR_SEL, SEL_VALID, ERR
    );

    modport slave (
        input  REQ_VALID, REQ_SEL, REQ_OFF,
        output REQ_READY, S, CUR_SEL, SEL_VALID, ERR
    );
endinterface

// File: rtl/nem_ohmux_sel_ctrl_dwell_cnt.sv
// Down-counter timing the break and make dwells of the relay sequencer.
// Latency: done asserts load_val-1 enabled cycles after the load edge.
// Backpressure: none; holds at 1 (no wrap) until reloaded.
// Ports: clk, rst (sync, high), load/load_val, en, done (count == 1).
module nem_dwell_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q > W'(1))) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// Break-before-make sequencer driving one-hot NEM-relay mux select lanes.
// Latency: accepted change -> S=0 for BREAK_CYC, lane closed for MAKE_CYC, then SEL_VALID.
// Backpressure: REQ_READY low while breaking/making; high in IDLE and HOLD only.
// Ports: CLK, RST (sync, high); bus = request in, lanes S/CUR_SEL/SEL_VALID/ERR out.
module nem_ohmux_sel_ctrl
    import nem_sel_pkg::*;
#(
    parameter int N_IN      = 2,
    parameter int BREAK_CYC = BREAK_CYC_DEF,
    parameter int MAKE_CYC  = MAKE_CYC_DEF,
    parameter int SEL_W     = $clog2(N_IN)
) (
    input  logic                  CLK,
    input  logic                  RST,
    nem_ohmux_sel_ctrl_if.slave   bus
);

    localparam int DWELL_MAX = (BREAK_CYC > MAKE_CYC) ? BREAK_CYC : MAKE_CYC;
    localparam int CNT_W     = $clog2(DWELL_MAX + 1);

    sel_state_t       state_q, state_nxt;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_nxt;
    logic [SEL_W-1:0] tgt_q, tgt_nxt;
    logic             tgt_off_q, tgt_off_nxt;
    logic             err_nxt;
    logic             s_dummy;
    logic [N_IN-1:0]  s_q;
    logic             sel_valid_q;
    logic             ready_q;
    logic             err_q;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_en;
    logic             cnt_done;

    logic             accept;
    logic             sel_oor;

    assign s_dummy = 1'b0;
    assign accept  = bus.REQ_VALID & ready_q;
    assign sel_oor = !bus.REQ_OFF && (32'(bus.REQ_SEL) >= 32'(N_IN));
    assign cnt_en  = (state_q == ST_BREAK) || (state_q == ST_MAKE);

    nem_dwell_cnt #(
        .W (CNT_W)
    ) u_dwell (
        .clk      (CLK),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    always_comb begin
        state_nxt    = state_q;
        cur_sel_nxt  = cur_sel_q;
        tgt_nxt      = tgt_q;
        tgt_off_nxt  = tgt_off_q;
        err_nxt      = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (sel_oor) begin
                        // Bad index is consumed and flagged; relays untouched.
                        err_nxt = 1'b1;
                    end else if (bus.REQ_OFF) begin
                        // Off from IDLE is a no-op: lanes are already open.
                        if (state_q == ST_HOLD) begin
                            tgt_off_nxt  = 1'b1;
                            state_nxt    = ST_BREAK;
                            cnt_load     = 1'b1;
                            cnt_load_val = CNT_W'(BREAK_CYC);
                        end
                    end else if ((state_q == ST_HOLD) && (bus.REQ_SEL == cur_sel_q)) begin
                        // Already settled on this lane; keep the relay closed.
                        state_nxt = ST_HOLD;
                    end else begin
                        // From IDLE too: relay position after reset is unknown,
                        // so always run the full break before making.
                        tgt_nxt      = bus.REQ_SEL;
                        tgt_off_nxt  = 1'b0;
                        state_nxt    = ST_BREAK;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(BREAK_CYC);
                    end
                end
            end
            ST_BREAK: begin
                if (cnt_done) begin
                    if (tgt_off_q) begin
                        state_nxt   = ST_IDLE;
                        cur_sel_nxt = '0;
                        tgt_off_nxt = 1'b0;
                    end else begin
                        state_nxt    = ST_MAKE;
                        cur_sel_nxt  = tgt_q;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(MAKE_CYC);
                    end
                end
            end
            ST_MAKE: begin
                if (cnt_done) begin
                    state_nxt = ST_HOLD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they change
    // exactly on the edge the state does, with no decode glitches on S.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cur_sel_q   <= '0;
            tgt_q       <= '0;
            tgt_off_q   <= 1'b0;
            s_q         <= '0;
            sel_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cur_sel_q   <= cur_sel_nxt;
            tgt_q       <= tgt_nxt;
            tgt_off_q   <= tgt_off_nxt;
            s_q         <= ((state_nxt == ST_MAKE) || (state_nxt == ST_HOLD))
                           ? N_IN'(onehot(32'(cur_sel_nxt), N_IN)) : {N_IN{s_dummy}};
            sel_valid_q <= (state_nxt == ST_HOLD);
            ready_q     <= (state_nxt == ST_IDLE) || (state_nxt == ST_HOLD);
            err_q       <= err_nxt;
        end
    end

    assign bus.S         = s_q;
    assign bus.CUR_SEL   = cur_sel_q;
    assign bus.SEL_VALID = sel_valid_q;
    assign bus.REQ_READY = ready_q;
    assign bus.ERR       = err_q;

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
module tb_nem_ohmux_sel_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    nem_ohmux_sel_ctrl_if #(.N_IN(2)) bus2 ();
    nem_ohmux_sel_ctrl_if #(.N_IN(3)) bus3 ();

    nem_ohmux_sel_ctrl #(.N_IN(2), .BREAK_CYC(4), .MAKE_CYC(8)) u_dut2 (
        .CLK (clk),
        .RST (rst),
        .bus (bus2)
    );

    nem_ohmux_sel_ctrl #(.N_IN(3), .BREAK_CYC(4), .MAKE_CYC(8)) u_dut3 (
        .CLK (clk),
        .RST (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus2.REQ_VALID = 1'b1; bus2.REQ_SEL = 1'b1; bus2.REQ_OFF = 1'b0;
        bus3.REQ_VALID = 1'b1; bus3.REQ_SEL = 2'd2; bus3.REQ_OFF = 1'b0;
        tick(); tick();
        bus2.REQ_VALID = 1'b0; bus3.REQ_VALID = 1'b0;
        vectors++;
        if (bus2.S !== 2'b00 || bus2.CUR_SEL !== 1'b0 || bus2.SEL_VALID !== 1'b0 ||
            bus2.ERR !== 1'b0 || bus2.REQ_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_n2 S=%b CUR=%b V=%b ERR=%b RDY=%b want 00 0 0 0 1",
                     bus2.S, bus2.CUR_SEL, bus2.SEL_VALID, bus2.ERR, bus2.REQ_READY);
        end
        vectors++;
        if (bus3.S !== 3'b000 || bus3.CUR_SEL !== 2'd0 || bus3.SEL_VALID !== 1'b0 ||
            bus3.ERR !== 1'b0 || bus3.REQ_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_n3 S=%b CUR=%0d V=%b ERR=%b RDY=%b want 000 0 0 0 1",
                     bus3.S, bus3.CUR_SEL, bus3.SEL_VALID, bus3.ERR, bus3.REQ_READY);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (bus2.S !== 2'b00 || bus2.REQ_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_after_reset S=%b RDY=%b want 00 1", bus2.S, bus2.REQ_READY);
        end
    endtask

    // Request lane 1 from IDLE and walk the whole break/make profile.
    task automatic test_first_select();
        logic [1:0] exp_s;
        bus2.REQ_VALID = 1'b1; bus2.REQ_SEL = 1'b1; bus2.REQ_OFF = 1'b0;
        tick();
        bus2.REQ_VALID = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            exp_s = (k <= 4) ? 2'b00 : 2'b10;
            vectors++;
            if (bus2.S !== exp_s || bus2.SEL_VALID !== (k == 13) || bus2.REQ_READY !== (k == 13)) begin
                miscompares++;
                $display("FAIL first_select t+%0d S=%b V=%b RDY=%b want %b %b %b",
                         k, bus2.S, bus2.SEL_VALID, bus2.REQ_READY, exp_s, (k == 13), (k == 13));
            end
            if (k >= 5) begin
                vectors++;
                if (bus2.CUR_SEL !== 1'b1) begin
                    miscompares++;
                    $display("FAIL first_select_cur t+%0d CUR=%b want 1", k, bus2.CUR_SEL);
                end
            end
            tick();
        end
    endtask

    // HOLD on lane 1 -> lane 0: must pass through 00, never 11.
    task automatic test_switch();
        logic [1:0] exp_s;
        bus2.REQ_VALID = 1'b1; bus2.REQ_SEL = 1'b0; bus2.REQ_OFF = 1'b0;
        tick();
        bus2.REQ_VALID = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            exp_s = (k <= 4) ? 2'b00 : 2'b01;
            vectors++;
            if (bus2.S !== exp_s || bus2.SEL_VALID !== (k == 13)) begin
                miscompares++;
                $display("FAIL switch t+%0d S=%b V=%b want %b %b",
                         k, bus2.S, bus2.SEL_VALID, exp_s, (k == 13));
            end
            tick();
        end
        vectors++;
        if (bus2.CUR_SEL !== 1'b0) begin
            miscompares++;
            $display("FAIL switch_cur CUR=%b want 0", bus2.CUR_SEL);
        end
    endtask

    // Re-request the lane already held: accepted, nothing moves.
    task automatic test_same_sel();
        vectors++;
        if (bus2.REQ_READY !== 1'b1) begin
            miscompares++;
            $display("FAIL same_sel_ready RDY=%b want 1", bus2.REQ_READY);
        end
        bus2.REQ_VALID = 1'b1; bus2.REQ_SEL = 1'b0; bus2.REQ_OFF = 1'b0;
        tick();
        bus2.REQ_VALID = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            vectors++;
            if (bus2.S !== 2'b01 || bus2.CUR_SEL !== 1'b0 || bus2.SEL_VALID !== 1'b1 ||
                bus2.REQ_READY !== 1'b1) begin
                miscompares++;
                $display("FAIL same_sel t+%0d S=%b CUR=%b V=%b RDY=%b want 01 0 1 1",
                         k, bus2.S, bus2.CUR_SEL, bus2.SEL_VALID, bus2.REQ_READY);
            end
            tick();
        end
    endtask

    // OFF from HOLD breaks then idles; OFF from IDLE changes nothing.
    task automatic test_off();
        bus2.REQ_VALID = 1'b1; bus2.REQ_SEL = 1'b1; bus2.REQ_OFF = 1'b1;
        tick();
        bus2.REQ_VALID = 1'b0; bus2.REQ_OFF = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            vectors++;
            if (bus2.S !== 2'b00 || bus2.SEL_VALID !== 1'b0 || bus2.REQ_READY !== (k == 5)) begin
                miscompares++;
                $display("FAIL off_hold t+%0d S=%b V=%b RDY=%b want 00 0 %b",
                         k, bus2.S, bus2.SEL_VALID, bus2.REQ_READY, (k == 5));
            end
            tick();
        end
        vectors++;
        if (bus2.CUR_SEL !== 1'b0) begin
            miscompares++;
            $display("FAIL off_cur CUR=%b want 0", bus2.CUR_SEL);
        end
        bus2.REQ_VALID = 1'b1; bus2.REQ_SEL = 1'b1; bus2.REQ_OFF = 1'b1;
        tick();
        bus2.REQ_VALID = 1'b0; bus2.REQ_OFF = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            vectors++;
            if (bus2.S !== 2'b00 || bus2.REQ_READY !== 1'b1 || bus2.SEL_VALID !== 1'b0) begin
                miscompares++;
                $display("FAIL off_idle t+%0d S=%b RDY=%b V=%b want 00 1 0",
                         k, bus2.S, bus2.REQ_READY, bus2.SEL_VALID);
            end
            tick();
        end
    endtask

    // Reset during MAKE opens the lane; the next request needs the full dwell.
    task automatic test_reset_mid_make();
        bus2.REQ_VALID = 1'b1; bus2.REQ_SEL = 1'b1; bus2.REQ_OFF = 1'b0;
        tick();
        bus2.REQ_VALID = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        vectors++;
        if (bus2.S !== 2'b10 || bus2.SEL_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_make S=%b V=%b want 10 0", bus2.S, bus2.SEL_VALID);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (bus2.S !== 2'b00 || bus2.SEL_VALID !== 1'b0 || bus2.REQ_READY !== 1'b1 ||
            bus2.CUR_SEL !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_make S=%b V=%b RDY=%b CUR=%b want 00 0 1 0",
                     bus2.S, bus2.SEL_VALID, bus2.REQ_READY, bus2.CUR_SEL);
        end
        bus2.REQ_VALID = 1'b1; bus2.REQ_SEL = 1'b0; bus2.REQ_OFF = 1'b0;
        tick();
        bus2.REQ_VALID = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            if (k == 4 || k == 5 || k == 12 || k == 13) begin
                vectors++;
                if (bus2.S !== ((k == 4) ? 2'b00 : 2'b01) || bus2.SEL_VALID !== (k == 13)) begin
                    miscompares++;
                    $display("FAIL post_rst t+%0d S=%b V=%b want %b %b", k, bus2.S,
                             bus2.SEL_VALID, ((k == 4) ? 2'b00 : 2'b01), (k == 13));
                end
            end
            tick();
        end
    endtask

    // Three-lane instance: out-of-range index in HOLD only pulses ERR.
    task automatic test_err_range();
        bus3.REQ_VALID = 1'b1; bus3.REQ_SEL = 2'd2; bus3.REQ_OFF = 1'b0;
        tick();
        bus3.REQ_VALID = 1'b0;
        for (int k = 1; k < 13; k++) tick();
        vectors++;
        if (bus3.S !== 3'b100 || bus3.CUR_SEL !== 2'd2 || bus3.SEL_VALID !== 1'b1) begin
            miscompares++;
            $display("FAIL n3_hold S=%b CUR=%0d V=%b want 100 2 1",
                     bus3.S, bus3.CUR_SEL, bus3.SEL_VALID);
        end
        bus3.REQ_VALID = 1'b1; bus3.REQ_SEL = 2'd3;
        tick();
        bus3.REQ_VALID = 1'b0; bus3.REQ_SEL = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            vectors++;
            if (bus3.ERR !== (k == 1) || bus3.S !== 3'b100 || bus3.CUR_SEL !== 2'd2 ||
                bus3.REQ_READY !== 1'b1 || bus3.SEL_VALID !== 1'b1) begin
                miscompares++;
                $display("FAIL err_pulse t+%0d ERR=%b S=%b CUR=%0d RDY=%b V=%b want %b 100 2 1 1",
                         k, bus3.ERR, bus3.S, bus3.CUR_SEL, bus3.REQ_READY, bus3.SEL_VALID, (k == 1));
            end
            tick();
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus2.REQ_VALID = 1'b0; bus2.REQ_SEL = '0; bus2.REQ_OFF = 1'b0;
        bus3.REQ_VALID = 1'b0; bus3.REQ_SEL = '0; bus3.REQ_OFF = 1'b0;
        #2;
        test_reset();
        test_first_select();
        test_switch();
        test_same_sel();
        test_off();
        test_reset_mid_make();
        test_err_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
